// File: rtl/led_matrix_scanner.sv
// Double-buffered row-scan driver for an N_ROWS x N_COLS LED matrix.
// Frames arrive over valid/ready into a shadow buffer and go live only at a frame boundary.
module led_matrix_scanner #(
    parameter int N_ROWS         = 15,
    parameter int N_COLS         = 15,
    parameter int DIVIDER        = 1000,
    parameter int BLANK_CYCLES   = 2,
    parameter bit ROW_ACTIVE_LOW = 1'b0,
    parameter bit COL_ACTIVE_LOW = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [N_ROWS*N_COLS-1:0]   load_pixels,
    output logic [N_ROWS-1:0]          rows,
    output logic [N_COLS-1:0]          cols,
    output logic                       frame_done,
    output logic [$clog2(N_ROWS)-1:0]  row_idx
);

    localparam int ROW_W   = $clog2(N_ROWS);
    localparam int PIX_W   = N_ROWS * N_COLS;
    localparam int CNT_MAX = (DIVIDER > BLANK_CYCLES) ? DIVIDER : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  DRV_LAST = CNT_W'(DIVIDER - 1);
    localparam logic [CNT_W-1:0]  BLK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(N_ROWS - 1);
    localparam logic [N_ROWS-1:0] ROW_IDLE = {N_ROWS{ROW_ACTIVE_LOW}};
    localparam logic [N_COLS-1:0] COL_IDLE = {N_COLS{COL_ACTIVE_LOW}};

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } state_e;

    // With no blanking the scan lives permanently in DRIVE.
    localparam state_e START_STATE = (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               frame_end;

    logic [PIX_W-1:0]   active_q, active_d;
    logic [PIX_W-1:0]   shadow_q, shadow_d;
    logic               pending_q, pending_d;
    logic               xfer, swap;

    logic [N_ROWS-1:0]  rows_q, rows_d;
    logic [N_COLS-1:0]  cols_q, cols_d;
    logic               frame_done_q, frame_done_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= START_STATE;
            row_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        frame_end = 1'b0;
        if (!en) begin
            state_d = START_STATE;
            row_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_BLANK: begin
                    if (cnt_q == BLK_LAST) begin
                        state_d = S_DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (cnt_q == DRV_LAST) begin
                        state_d = START_STATE;
                        cnt_d   = '0;
                        if (row_q == ROW_LAST) begin
                            row_d     = '0;
                            frame_end = 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = START_STATE;
            endcase
        end
    end

    // Swap at a frame end or while disabled; a transfer needs pending clear, so the two never collide.
    always_comb begin
        xfer      = load_valid && !pending_q;
        swap      = pending_q && (frame_end || !en);
        shadow_d  = xfer ? load_pixels : shadow_q;
        active_d  = swap ? shadow_q : active_q;
        pending_d = xfer || (pending_q && !swap);
    end

    // Outputs follow the next state so they line up with state_q / row_idx in the same cycle.
    always_comb begin
        rows_d       = ROW_IDLE;
        cols_d       = COL_IDLE;
        frame_done_d = frame_end;
        if (en && state_d == S_DRIVE) begin
            rows_d = ROW_IDLE ^ (N_ROWS'(1) << row_d);
            cols_d = COL_IDLE ^ active_d[int'(row_d) * N_COLS +: N_COLS];
        end
    end

    // NOTE: the frame buffers are ordinary flops and are cleared on reset so nothing stale is shown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            rows_q       <= ROW_IDLE;
            cols_q       <= COL_IDLE;
            frame_done_q <= 1'b0;
        end else begin
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rows       = rows_q;
    assign cols       = cols_q;
    assign frame_done = frame_done_q;
    assign row_idx    = row_q;
    assign load_ready = ~pending_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner: three 3x4 instances covering blanked scan,
// no-blank scan, and active-low rows with enable gating.
module tb_led_matrix_scanner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc    = 0;
    int total  = 0;
    int passed = 0;

    // Instance A: DIVIDER=2, BLANK_CYCLES=1, active-high.
    logic        en_a = 1'b1, lv_a = 1'b0, lr_a, fd_a;
    logic [11:0] lp_a = '0;
    logic [2:0]  rows_a;
    logic [3:0]  cols_a;
    logic [1:0]  ri_a;
    logic [9:0]  obs_a;
    logic [11:0] a_model = '0;

    // Instance B: DIVIDER=1, BLANK_CYCLES=0.
    logic        en_b = 1'b1, lv_b = 1'b0, lr_b, fd_b;
    logic [11:0] lp_b = '0;
    logic [2:0]  rows_b;
    logic [3:0]  cols_b;
    logic [1:0]  ri_b;

    // Instance C: as A but with active-low rows.
    logic        en_c = 1'b1, lv_c = 1'b0, lr_c, fd_c;
    logic [11:0] lp_c = '0;
    logic [2:0]  rows_c;
    logic [3:0]  cols_c;
    logic [1:0]  ri_c;
    logic [9:0]  obs_c;

    assign obs_a = {rows_a, cols_a, ri_a, fd_a};
    assign obs_c = {rows_c, cols_c, ri_c, fd_c};

    led_matrix_scanner #(.N_ROWS(3), .N_COLS(4), .DIVIDER(2), .BLANK_CYCLES(1),
                         .ROW_ACTIVE_LOW(1'b0), .COL_ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .load_valid(lv_a), .load_ready(lr_a),
        .load_pixels(lp_a), .rows(rows_a), .cols(cols_a), .frame_done(fd_a), .row_idx(ri_a));

    led_matrix_scanner #(.N_ROWS(3), .N_COLS(4), .DIVIDER(1), .BLANK_CYCLES(0),
                         .ROW_ACTIVE_LOW(1'b0), .COL_ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .load_valid(lv_b), .load_ready(lr_b),
        .load_pixels(lp_b), .rows(rows_b), .cols(cols_b), .frame_done(fd_b), .row_idx(ri_b));

    led_matrix_scanner #(.N_ROWS(3), .N_COLS(4), .DIVIDER(2), .BLANK_CYCLES(1),
                         .ROW_ACTIVE_LOW(1'b1), .COL_ACTIVE_LOW(1'b0)) dut_c (
        .clk(clk), .rst(rst), .en(en_c), .load_valid(lv_c), .load_ready(lr_c),
        .load_pixels(lp_c), .rows(rows_c), .cols(cols_c), .frame_done(fd_c), .row_idx(ri_c));

    // Expected {rows, cols, row_idx, frame_done} for a 3x4 scan with 1 blank + 2 drive cycles
    // per row, c cycles after the scan started at row 0 in BLANK.
    function automatic logic [9:0] exp_vec(input int c, input logic [11:0] act);
        int         ph;
        int         r;
        logic [2:0] rw;
        logic [3:0] cl;
        ph = c % 3;
        r  = (c / 3) % 3;
        rw = '0;
        cl = '0;
        if (ph != 0) begin
            rw[r] = 1'b1;
            cl    = act[r*4 +: 4];
        end
        return {rw, cl, 2'(r), (c % 9 == 0) && (c != 0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        total++;
        if (obs_a !== 10'b0 || lr_a !== 1'b1) $display("FAIL reset_a got=%b lr=%b want=%b lr=1", obs_a, lr_a, 10'b0);
        else passed++;
        total++;
        if ({rows_b, cols_b, ri_b, fd_b} !== 10'b0 || lr_b !== 1'b1)
            $display("FAIL reset_b got=%b want=%b", {rows_b, cols_b, ri_b, fd_b}, 10'b0);
        else passed++;
        total++;
        if (obs_c !== 10'b111_0000_00_0) $display("FAIL reset_c got=%b want=%b", obs_c, 10'b111_0000_00_0);
        else passed++;
    endtask

    task automatic test_scan_timing();
        while (cyc < 18) begin
            step();
            total++;
            if (obs_a !== exp_vec(cyc, a_model))
                $display("FAIL scan cyc=%0d got=%b want=%b", cyc, obs_a, exp_vec(cyc, a_model));
            else passed++;
        end
    endtask

    task automatic test_load_swap();
        while (cyc < 35) begin
            step();
            lv_a = (cyc == 19);
            lp_a = 12'h0A5;
            if (cyc == 27) a_model = 12'h0A5;
            total++;
            if (obs_a !== exp_vec(cyc, a_model) || lr_a !== !(cyc >= 20 && cyc < 27))
                $display("FAIL load_swap cyc=%0d got=%b lr=%b want=%b", cyc, obs_a, lr_a, exp_vec(cyc, a_model));
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        while (cyc < 71) begin
            step();
            lv_a = 1'b0;
            if (cyc == 37) begin lv_a = 1'b1; lp_a = 12'h111; end
            if (cyc >= 38 && cyc <= 42) begin lv_a = 1'b1; lp_a = 12'hFFF; end
            if (cyc == 53) begin lv_a = 1'b1; lp_a = 12'h7E3; end
            if (cyc == 45) a_model = 12'h111;
            if (cyc == 63) a_model = 12'h7E3;
            total++;
            if (obs_a !== exp_vec(cyc, a_model) ||
                lr_a !== !((cyc >= 38 && cyc < 45) || (cyc >= 54 && cyc < 63)))
                $display("FAIL back_to_back cyc=%0d got=%b lr=%b want=%b", cyc, obs_a, lr_a, exp_vec(cyc, a_model));
            else passed++;
        end
    endtask

    task automatic test_no_blank();
        logic [9:0] want;
        while (cyc < 80) begin
            step();
            want = {3'b001 << (cyc % 3), 4'b0000, 2'(cyc % 3), (cyc % 3 == 0)};
            total++;
            if ({rows_b, cols_b, ri_b, fd_b} !== want)
                $display("FAIL no_blank cyc=%0d got=%b want=%b", cyc, {rows_b, cols_b, ri_b, fd_b}, want);
            else passed++;
        end
    endtask

    task automatic test_enable();
        logic [9:0] want;
        while (cyc < 108) begin
            step();
            lv_c = (cyc == 81);
            lp_c = 12'h5A3;
            if (cyc == 85) en_c = 1'b0;
            if (cyc == 90) en_c = 1'b1;
            if (cyc <= 85)      want = exp_vec(cyc, 12'h000);
            else if (cyc < 90)  want = exp_vec(0, 12'h000);
            else                want = exp_vec(cyc - 90, 12'h5A3);
            want[9:7] = ~want[9:7];
            total++;
            if (obs_c !== want || lr_c !== !(cyc >= 82 && cyc < 86))
                $display("FAIL enable cyc=%0d got=%b lr=%b want=%b", cyc, obs_c, lr_c, want);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        while (cyc < 112) begin
            step();
            lv_a = (cyc == 110);
            lp_a = 12'hFFF;
        end
        total++;
        if (obs_a !== exp_vec(cyc, a_model) || lr_a !== 1'b0)
            $display("FAIL pre_reset got=%b lr=%b want=%b lr=0", obs_a, lr_a, exp_vec(cyc, a_model));
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if (obs_a !== 10'b0 || lr_a !== 1'b1 || rows_c !== 3'b111)
            $display("FAIL async_reset got=%b lr=%b rows_c=%b want=%b lr=1 rows_c=111", obs_a, lr_a, rows_c, 10'b0);
        else passed++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        a_model = '0;
        while (cyc < 18) begin
            step();
            total++;
            if (obs_a !== exp_vec(cyc, a_model) || lr_a !== 1'b1)
                $display("FAIL post_reset cyc=%0d got=%b lr=%b want=%b", cyc, obs_a, lr_a, exp_vec(cyc, a_model));
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_scan_timing();
        test_load_swap();
        test_back_to_back();
        test_no_blank();
        test_enable();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
